// File: rtl/utim64_pkg.sv
// Shared definitions for the utim64 timer: register map, controller state
// encoding and the active-low word-enable codes of the 64-bit counter.
package utim64_pkg;

   localparam logic [1:0] UTIM64_ADDR_CONF = 2'd0;
   localparam logic [1:0] UTIM64_ADDR_LO   = 2'd1;
   localparam logic [1:0] UTIM64_ADDR_HI   = 2'd2;
   localparam logic [1:0] UTIM64_ADDR_RSV  = 2'd3;

   localparam logic [1:0] DQM_LO   = 2'b10;
   localparam logic [1:0] DQM_HI   = 2'b01;
   localparam logic [1:0] DQM_NONE = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_STOP = 2'd1,
      ST_LOAD = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   // Kind of write held while the FSM walks through LOAD.
   typedef enum logic [1:0] {
      OP_CONF  = 2'd0,
      OP_COUNT = 2'd1,
      OP_RSV   = 2'd2
   } op_t;

endpackage

// File: rtl/utim64_counter_ctrl_if.sv
// Single-beat register request/response bus of the utim64 counter controller.
interface utim64_counter_ctrl_if;
   import utim64_pkg::*;

   logic        iREQ_VALID;
   logic        oREQ_BUSY;
   logic        iREQ_RW;
   logic [1:0]  iREQ_ADDR;
   logic [31:0] iREQ_DATA;
   logic        oRESP_VALID;
   logic [31:0] oRESP_DATA;

   modport master (
      output iREQ_VALID, iREQ_RW, iREQ_ADDR, iREQ_DATA,
      input  oREQ_BUSY, oRESP_VALID, oRESP_DATA
   );

   modport slave (
      input  iREQ_VALID, iREQ_RW, iREQ_ADDR, iREQ_DATA,
      output oREQ_BUSY, oRESP_VALID, oRESP_DATA
   );

endinterface

// File: rtl/utim64_counter_ctrl.sv
// Register front-end for the utim64 64-bit counter: coherent 64-bit reads via a
// low-word snapshot, and count writes that stop/load/restart a running counter.
module utim64_counter_ctrl
   import utim64_pkg::*;
#(
   parameter bit          P_AUTO_RESTART = 1'b1,
   parameter logic [31:0] P_RSV_READ     = 32'h0000_0000
) (
   input  logic                  iCLOCK,
   input  logic                  inRESET,
   utim64_counter_ctrl_if.slave  bus,
   output logic                  oCONF_WRITE,
   output logic                  oCONF_ENA,
   output logic                  oCOUNT_WRITE,
   output logic [1:0]            onCOUNT_DQM,
   output logic [63:0]           oCOUNT_COUNTER,
   input  logic                  iWORKING,
   input  logic [63:0]           iCOUNTER
);

   state_t      state;
   state_t      state_nxt;
   op_t         op_q;
   logic        ena_q;
   logic        restart_q;
   logic [1:0]  dqm_q;
   logic [63:0] snapshot_q;
   logic        rd_vld_q;
   logic [31:0] rd_data_q;
   logic        accept;
   logic        is_count_addr;

   assign accept        = (state == ST_IDLE) && bus.iREQ_VALID;
   assign is_count_addr = (bus.iREQ_ADDR == UTIM64_ADDR_LO) ||
                          (bus.iREQ_ADDR == UTIM64_ADDR_HI);

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Reads never leave IDLE; every write spends one strobe cycle in LOAD so all
   // non-running writes share the same two-cycle completion.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept && bus.iREQ_RW) begin
               if (is_count_addr && iWORKING) begin
                  state_nxt = ST_STOP;
               end else begin
                  state_nxt = ST_LOAD;
               end
            end
         end
         ST_STOP: state_nxt = ST_LOAD;
         ST_LOAD: state_nxt = ST_RESP;
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         op_q           <= OP_RSV;
         ena_q          <= 1'b0;
         restart_q      <= 1'b0;
         dqm_q          <= DQM_NONE;
         oCOUNT_COUNTER <= '0;
         snapshot_q     <= '0;
         rd_vld_q       <= 1'b0;
         rd_data_q      <= '0;
      end else begin
         rd_vld_q  <= accept && !bus.iREQ_RW;
         rd_data_q <= '0;
         if (accept && !bus.iREQ_RW) begin
            case (bus.iREQ_ADDR)
               UTIM64_ADDR_CONF: rd_data_q <= {31'b0, iWORKING};
               UTIM64_ADDR_LO: begin
                  snapshot_q <= iCOUNTER;
                  rd_data_q  <= iCOUNTER[31:0];
               end
               UTIM64_ADDR_HI:   rd_data_q <= snapshot_q[63:32];
               default:          rd_data_q <= P_RSV_READ;
            endcase
         end else if (accept) begin
            case (bus.iREQ_ADDR)
               UTIM64_ADDR_CONF: begin
                  op_q  <= OP_CONF;
                  ena_q <= bus.iREQ_DATA[0];
               end
               UTIM64_ADDR_LO, UTIM64_ADDR_HI: begin
                  op_q           <= OP_COUNT;
                  oCOUNT_COUNTER <= {bus.iREQ_DATA, bus.iREQ_DATA};
                  dqm_q          <= (bus.iREQ_ADDR == UTIM64_ADDR_LO) ? DQM_LO : DQM_HI;
                  restart_q      <= iWORKING & P_AUTO_RESTART;
               end
               default:          op_q <= OP_RSV;
            endcase
         end
      end
   end

   assign bus.oREQ_BUSY   = (state != ST_IDLE);
   assign bus.oRESP_VALID = rd_vld_q || (state == ST_RESP);
   assign bus.oRESP_DATA  = rd_vld_q ? rd_data_q : 32'h0;

   // Strobes decode from state only, so an asserted reset drops them at once.
   always_comb begin
      oCONF_WRITE  = 1'b0;
      oCONF_ENA    = 1'b0;
      oCOUNT_WRITE = 1'b0;
      onCOUNT_DQM  = DQM_NONE;
      case (state)
         ST_STOP: oCONF_WRITE = 1'b1;
         ST_LOAD: begin
            case (op_q)
               OP_CONF: begin
                  oCONF_WRITE = 1'b1;
                  oCONF_ENA   = ena_q;
               end
               OP_COUNT: begin
                  oCOUNT_WRITE = 1'b1;
                  onCOUNT_DQM  = dqm_q;
                  if (restart_q) begin
                     oCONF_WRITE = 1'b1;
                     oCONF_ENA   = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_utim64_counter_ctrl.sv
// Bench for utim64_counter_ctrl: two controllers (auto-restart on/off), each driving
// a behavioural main_counter, checked every cycle against a transaction-level model.
module tb_utim64_counter_ctrl;
   import utim64_pkg::*;

   localparam logic [31:0] RSV_VAL = 32'hA5A5_0F0F;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       req_valid, req_rw;
   logic [1:0][1:0]  req_addr;
   logic [1:0][31:0] req_data;
   wire  [1:0]       busy, resp_valid, conf_write, conf_ena, count_write, working;
   wire  [1:0][31:0] resp_data;
   wire  [1:0][1:0]  dqm;
   wire  [1:0][63:0] cnt, ccnt;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [63:0] mv [2];
   logic [63:0] msnap [2];
   logic        mr [2];
   int          er_cyc [2];
   logic [31:0] er_data [2];
   int          bz_lo [2], bz_hi [2];
   int          run1_cyc [2], run2_cyc [2], load_cyc [2];
   logic        run1_val [2], run2_val [2];
   logic [31:0] load_data [2];
   logic        load_hi [2];
   logic        acc_flag [2];
   logic        saw_stop [2], saw_lr [2], saw_cw [2];

   for (genvar g = 0; g < 2; g++) begin : gen_dut
      utim64_counter_ctrl_if bus ();
      logic        working_q;
      logic [63:0] cnt_q;

      assign bus.iREQ_VALID = req_valid[g];
      assign bus.iREQ_RW    = req_rw[g];
      assign bus.iREQ_ADDR  = req_addr[g];
      assign bus.iREQ_DATA  = req_data[g];
      assign busy[g]        = bus.oREQ_BUSY;
      assign resp_valid[g]  = bus.oRESP_VALID;
      assign resp_data[g]   = bus.oRESP_DATA;
      assign working[g]     = working_q;
      assign cnt[g]         = cnt_q;

      utim64_counter_ctrl #(.P_AUTO_RESTART(g == 0), .P_RSV_READ(RSV_VAL)) dut (
         .iCLOCK         (clk),
         .inRESET        (rst_n),
         .bus            (bus),
         .oCONF_WRITE    (conf_write[g]),
         .oCONF_ENA      (conf_ena[g]),
         .oCOUNT_WRITE   (count_write[g]),
         .onCOUNT_DQM    (dqm[g]),
         .oCOUNT_COUNTER (ccnt[g]),
         .iWORKING       (working_q),
         .iCOUNTER       (cnt_q)
      );

      // main_counter: ignores count writes while running, config lands next cycle
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            working_q <= 1'b0;
            cnt_q     <= '0;
         end else begin
            if (count_write[g] && !working_q) begin
               if (!dqm[g][0]) cnt_q[31:0]  <= ccnt[g][31:0];
               if (!dqm[g][1]) cnt_q[63:32] <= ccnt[g][63:32];
            end else if (working_q) begin
               cnt_q <= cnt_q + 64'd1;
            end
            if (conf_write[g]) working_q <= conf_ena[g];
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset(input int k);
      mv[k] = '0;  msnap[k] = '0;  mr[k] = 1'b0;
      er_cyc[k] = -1;  er_data[k] = '0;  bz_lo[k] = 1;  bz_hi[k] = 0;
      run1_cyc[k] = -1;  run2_cyc[k] = -1;  load_cyc[k] = -1;
      run1_val[k] = 1'b0;  run2_val[k] = 1'b0;  load_data[k] = '0;  load_hi[k] = 1'b0;
      acc_flag[k] = 1'b0;
   endfunction

   // Model: v(n+1) = v(n) + running(n), overridden by the scheduled effects of writes.
   initial begin
      logic        exp_busy, exp_vld;
      logic [63:0] nv;
      logic        nr;
      logic [31:0] d;
      int          lat;
      for (int k = 0; k < 2; k++) begin
         model_reset(k);
         saw_stop[k] = 1'b0;  saw_lr[k] = 1'b0;  saw_cw[k] = 1'b0;
      end
      forever begin
         @(negedge clk);
         cyc++;
         for (int k = 0; k < 2; k++) begin
            if (!rst_n) model_reset(k);
            exp_busy = (cyc >= bz_lo[k]) && (cyc <= bz_hi[k]);
            exp_vld  = (er_cyc[k] == cyc);
            chk($sformatf("busy%0d", k), {63'b0, busy[k]}, {63'b0, exp_busy});
            chk($sformatf("resp_valid%0d", k), {63'b0, resp_valid[k]}, {63'b0, exp_vld});
            if (exp_vld) chk($sformatf("resp_data%0d", k), {32'b0, resp_data[k]}, {32'b0, er_data[k]});
            chk($sformatf("working%0d", k), {63'b0, working[k]}, {63'b0, mr[k]});
            chk($sformatf("counter%0d", k), cnt[k], mv[k]);
            chk($sformatf("cw_while_running%0d", k), {63'b0, count_write[k] & working[k]}, 64'd0);
            if (conf_write[k] && !conf_ena[k] && !count_write[k]) saw_stop[k] = 1'b1;
            if (count_write[k] && conf_write[k] && conf_ena[k])   saw_lr[k]   = 1'b1;
            if (count_write[k])                                    saw_cw[k]   = 1'b1;
            acc_flag[k] = 1'b0;
            if (rst_n) begin
               if (req_valid[k] && !exp_busy) begin
                  acc_flag[k] = 1'b1;
                  if (!req_rw[k]) begin
                     case (req_addr[k])
                        UTIM64_ADDR_CONF: d = {31'b0, mr[k]};
                        UTIM64_ADDR_LO: begin
                           d = mv[k][31:0];
                           msnap[k] = mv[k];
                        end
                        UTIM64_ADDR_HI:   d = msnap[k][63:32];
                        default:          d = RSV_VAL;
                     endcase
                     er_cyc[k]  = cyc + 1;
                     er_data[k] = d;
                  end else begin
                     run1_cyc[k] = -1;  run2_cyc[k] = -1;  load_cyc[k] = -1;
                     lat = 2;
                     if (req_addr[k] == UTIM64_ADDR_CONF) begin
                        run1_cyc[k] = cyc + 2;
                        run1_val[k] = req_data[k][0];
                     end else if (req_addr[k] != UTIM64_ADDR_RSV) begin
                        load_data[k] = req_data[k];
                        load_hi[k]   = (req_addr[k] == UTIM64_ADDR_HI);
                        if (mr[k]) begin
                           lat = 3;
                           run1_cyc[k] = cyc + 2;  run1_val[k] = 1'b0;
                           run2_cyc[k] = cyc + 3;  run2_val[k] = (k == 0);
                           load_cyc[k] = cyc + 3;
                        end else begin
                           load_cyc[k] = cyc + 2;
                        end
                     end
                     er_cyc[k]  = cyc + lat;
                     er_data[k] = 32'h0;
                     bz_lo[k]   = cyc + 1;
                     bz_hi[k]   = cyc + lat;
                  end
               end
               nv = mv[k] + {63'b0, mr[k]};
               nr = mr[k];
               if (run1_cyc[k] == cyc + 1) nr = run1_val[k];
               if (run2_cyc[k] == cyc + 1) nr = run2_val[k];
               if (load_cyc[k] == cyc + 1)
                  nv = load_hi[k] ? {load_data[k], mv[k][31:0]} : {mv[k][63:32], load_data[k]};
               mv[k] = nv;
               mr[k] = nr;
            end
         end
      end
   end

   task automatic do_req(input int k, input logic rw, input logic [1:0] addr,
                         input logic [31:0] data, output logic [31:0] rdata, output int lat);
      int w;
      @(posedge clk); #1;
      req_valid[k] = 1'b1;  req_rw[k] = rw;  req_addr[k] = addr;  req_data[k] = data;
      w = 0;
      forever begin
         @(negedge clk);
         if (!busy[k]) break;
         w++;
         if (w > 50) begin
            chk("accept_timeout", 64'd1, 64'd0);
            break;
         end
      end
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
      lat = 1;
      forever begin
         @(negedge clk);
         if (resp_valid[k]) break;
         lat++;
         if (lat > 10) begin
            chk("resp_timeout", 64'd1, 64'd0);
            break;
         end
      end
      rdata = resp_data[k];
   endtask

   task automatic rand_drive(input int k, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (req_valid[k] && !acc_flag[k]) continue;
         req_valid[k] = 1'b0;
         if ($urandom_range(0, 2) != 0) begin
            req_valid[k] = 1'b1;
            req_rw[k]    = 1'($urandom_range(0, 1));
            req_addr[k]  = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
               0:       req_data[k] = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
               1:       req_data[k] = 32'($urandom_range(0, 1));
               default: req_data[k] = $urandom;
            endcase
         end
      end
      for (int j = 0; j < 20 && req_valid[k]; j++) begin
         @(posedge clk); #1;
         if (acc_flag[k]) req_valid[k] = 1'b0;
      end
      req_valid[k] = 1'b0;
      repeat (5) @(posedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, lo, hi;
      int          lat;
      req_valid = '0;  req_rw = '0;  req_addr = '0;  req_data = '0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      @(negedge clk);
      chk("rst_strobes", {61'b0, conf_write[0], conf_ena[0], count_write[0]}, 64'd0);
      chk("rst_dqm", {62'b0, dqm[0]}, 64'd3);
      chk("rst_busy", {62'b0, busy}, 64'd0);
      do_req(0, 1'b0, UTIM64_ADDR_CONF, 32'h0, rd, lat);
      chk("rd_conf_after_rst", {32'b0, rd}, 64'd0);
      chk("rd_latency", lat, 64'd1);
      do_req(0, 1'b0, UTIM64_ADDR_HI, 32'h0, rd, lat);
      chk("rd_hi_after_rst", {32'b0, rd}, 64'd0);
      do_req(0, 1'b0, UTIM64_ADDR_RSV, 32'h0, rd, lat);
      chk("rd_rsv", {32'b0, rd}, {32'b0, RSV_VAL});

      do_req(0, 1'b1, UTIM64_ADDR_LO, 32'hDEAD_BEEF, rd, lat);
      chk("wr_lo_stopped_lat", lat, 64'd2);
      do_req(0, 1'b1, UTIM64_ADDR_HI, 32'h0000_0001, rd, lat);
      chk("wr_hi_stopped_lat", lat, 64'd2);
      do_req(0, 1'b0, UTIM64_ADDR_LO, 32'h0, rd, lat);
      chk("rd_lo_deadbeef", {32'b0, rd}, 64'hDEAD_BEEF);
      do_req(0, 1'b0, UTIM64_ADDR_HI, 32'h0, rd, lat);
      chk("rd_hi_one", {32'b0, rd}, 64'd1);

      do_req(0, 1'b1, UTIM64_ADDR_LO, 32'hFFFF_FFF0, rd, lat);
      do_req(0, 1'b1, UTIM64_ADDR_HI, 32'h0, rd, lat);
      do_req(0, 1'b1, UTIM64_ADDR_CONF, 32'h1, rd, lat);
      chk("wr_conf_lat", lat, 64'd2);
      repeat (100) @(posedge clk);
      do_req(0, 1'b0, UTIM64_ADDR_LO, 32'h0, lo, lat);
      do_req(0, 1'b0, UTIM64_ADDR_HI, 32'h0, hi, lat);
      chk("wrap_hi_from_snapshot", {32'b0, hi}, 64'd1);
      chk("wrap_lo_near_101", {63'b0, (lo >= 32'h54) && (lo <= 32'h56)}, 64'd1);

      saw_stop[0] = 1'b0;  saw_lr[0] = 1'b0;
      do_req(0, 1'b1, UTIM64_ADDR_LO, 32'h0000_1000, rd, lat);
      chk("wr_running_lat", lat, 64'd3);
      chk("wr_running_stop_seen", {63'b0, saw_stop[0]}, 64'd1);
      chk("wr_running_load_restart_seen", {63'b0, saw_lr[0]}, 64'd1);
      chk("wr_running_resumed", {63'b0, working[0]}, 64'd1);
      chk("wr_running_loaded", {32'b0, cnt[0][31:0]}, 64'h1000);

      do_req(1, 1'b1, UTIM64_ADDR_CONF, 32'h1, rd, lat);
      repeat (10) @(posedge clk);
      saw_lr[1] = 1'b0;  saw_cw[1] = 1'b0;
      do_req(1, 1'b1, UTIM64_ADDR_LO, 32'h0000_1000, rd, lat);
      chk("norestart_lat", lat, 64'd3);
      chk("norestart_no_restart", {63'b0, saw_lr[1]}, 64'd0);
      chk("norestart_count_write", {63'b0, saw_cw[1]}, 64'd1);
      chk("norestart_stopped", {63'b0, working[1]}, 64'd0);
      repeat (5) @(negedge clk);
      chk("norestart_holds", {32'b0, cnt[1][31:0]}, 64'h1000);

      fork
         rand_drive(0, 700);
         rand_drive(1, 700);
      join

      do_req(0, 1'b1, UTIM64_ADDR_CONF, 32'h1, rd, lat);
      @(posedge clk); #1;
      req_valid[0] = 1'b1;  req_rw[0] = 1'b1;  req_addr[0] = UTIM64_ADDR_LO;  req_data[0] = 32'h2222;
      @(negedge clk);
      chk("stop_req_accepted", {63'b0, busy[0]}, 64'd0);
      @(posedge clk); #2;
      chk("stop_strobe", {62'b0, conf_write[0], conf_ena[0]}, 64'd2);
      rst_n = 1'b0;
      #1;
      chk("rst_async_strobes", {61'b0, conf_write[0], conf_ena[0], count_write[0]}, 64'd0);
      chk("rst_async_busy", {63'b0, busy[0]}, 64'd0);
      req_valid[0] = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      do_req(0, 1'b0, UTIM64_ADDR_CONF, 32'h0, rd, lat);
      chk("rd_conf_after_midreset", {32'b0, rd}, 64'd0);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
